// File: rtl/clk_burst_scheduler_pkg.sv
// Shared types and constants for the burst clock scheduler and its pulse generator.
package clk_burst_scheduler_pkg;

  // Width of the requested pulse count.
  localparam int LEN_W = 8;

  // Output clock shaping modes.
  localparam logic MODE_DIV2 = 1'b0;
  localparam logic MODE_DIV4 = 1'b1;

  // Requester identities, used for both the owner output and the round-robin pointer.
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // Scheduler states: waiting, shaping pulses, and the single quiet cycle after a burst.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Phase value that closes one output period for the given mode.
  function automatic logic [1:0] last_phase(input logic mode);
    return (mode == MODE_DIV4) ? 2'd3 : 2'd1;
  endfunction

endpackage

// File: rtl/clk_burst_scheduler_burst_pulse_gen.sv
// Phase and remaining-pulse counters plus the registered burst clock output.
// The top tells it when a burst is granted (load) and while the FSM is in RUN;
// it reports back when the current RUN cycle is the last one of the burst.
module burst_pulse_gen
  import clk_burst_scheduler_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_mode,
  input  logic             i_run,
  input  logic             i_abort,
  output logic             o_clk_out,
  output logic             o_end
);

  logic [1:0]       r_phase;
  logic [LEN_W-1:0] r_remaining;
  logic             r_mode;
  logic             r_clk_out;

  logic             w_last;
  logic             w_end;
  logic [1:0]       w_phase_nxt;

  // Decode the end of a period and the end of the burst from the current counters.
  // A zero-length burst ends on its very first RUN cycle without any pulse.
  always_comb begin
    w_last      = (r_phase == last_phase(r_mode));
    w_end       = (r_remaining == '0) || (w_last && (r_remaining == LEN_W'(1)));
    w_phase_nxt = w_last ? 2'd0 : (r_phase + 2'd1);
  end

  // Load counters on a grant, advance them while running, and register clk_out
  // so that it is high exactly in phase 0 of every period of a live burst.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_phase     <= 2'd0;
      r_remaining <= '0;
      r_mode      <= MODE_DIV2;
      r_clk_out   <= 1'b0;
    end else if (i_load) begin
      r_phase     <= 2'd0;
      r_remaining <= i_len;
      r_mode      <= i_mode;
      r_clk_out   <= (i_len != '0);
    end else if (i_run) begin
      if (w_last && (r_remaining != '0)) begin
        r_remaining <= r_remaining - LEN_W'(1);
      end
      r_phase   <= w_phase_nxt;
      r_clk_out <= (w_phase_nxt == 2'd0) && !w_end && !i_abort;
    end else begin
      r_phase   <= 2'd0;
      r_clk_out <= 1'b0;
    end
  end

  assign o_clk_out = r_clk_out;
  assign o_end     = w_end;

endmodule

// File: rtl/clk_burst_scheduler.sv
// Round-robin burst clock scheduler: arbitrates two requesters, then emits a
// divided clock burst of the granted length followed by one quiet GAP cycle.
module clk_burst_scheduler
  import clk_burst_scheduler_pkg::*;
(
  input  logic             fastclk,
  input  logic             reset,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [LEN_W-1:0] len_a,
  input  logic [LEN_W-1:0] len_b,
  input  logic             mode_a,
  input  logic             mode_b,
  input  logic             abort,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             clk_out,
  output logic             busy,
  output logic             owner,
  output logic             done,
  output logic             aborted
);

  state_t           r_state;
  logic             r_gnt_a;
  logic             r_gnt_b;
  logic             r_done;
  logic             r_aborted;
  logic             r_owner;
  logic             r_ptr;

  state_t           w_state_nxt;
  logic             w_gnt_a_nxt;
  logic             w_gnt_b_nxt;
  logic             w_done_nxt;
  logic             w_aborted_nxt;
  logic             w_load;
  logic             w_pick_b;
  logic [LEN_W-1:0] w_len;
  logic             w_mode;
  logic             w_end;
  logic             w_run;

  // Round-robin choice: a lone requester wins, and on a tie the requester that
  // was not served last wins. The chosen requester's len/mode are forwarded.
  always_comb begin
    w_pick_b = req_b && (!req_a || (r_ptr == OWNER_A));
    w_len    = w_pick_b ? len_b  : len_a;
    w_mode   = w_pick_b ? mode_b : mode_a;
  end

  // Next-state and registered-output decode. GAP hands straight back to
  // arbitration, so a requester already waiting is granted in the cycle right
  // after GAP; with nothing pending GAP falls to IDLE. Abort wins over a
  // natural end in the same cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_a_nxt   = 1'b0;
    w_gnt_b_nxt   = 1'b0;
    w_done_nxt    = 1'b0;
    w_aborted_nxt = 1'b0;
    w_load        = 1'b0;
    case (r_state)
      ST_IDLE, ST_GAP: begin
        if (req_a || req_b) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
          w_gnt_a_nxt = !w_pick_b;
          w_gnt_b_nxt = w_pick_b;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt   = ST_GAP;
          w_done_nxt    = 1'b1;
          w_aborted_nxt = 1'b1;
        end else if (w_end) begin
          w_state_nxt   = ST_GAP;
          w_done_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, grant/done pulses, owner and round-robin pointer registers.
  // The pointer starts at B so that A wins the first tie.
  always_ff @(posedge fastclk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_gnt_a   <= 1'b0;
      r_gnt_b   <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_owner   <= OWNER_A;
      r_ptr     <= OWNER_B;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt_a   <= w_gnt_a_nxt;
      r_gnt_b   <= w_gnt_b_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_aborted_nxt;
      if (w_load) begin
        r_owner <= w_pick_b ? OWNER_B : OWNER_A;
        r_ptr   <= w_pick_b ? OWNER_B : OWNER_A;
      end
    end
  end

  assign w_run = (r_state == ST_RUN);

  burst_pulse_gen u_pulse_gen (
    .i_clk     (fastclk),
    .i_reset   (reset),
    .i_load    (w_load),
    .i_len     (w_len),
    .i_mode    (w_mode),
    .i_run     (w_run),
    .i_abort   (abort),
    .o_clk_out (clk_out),
    .o_end     (w_end)
  );

  assign gnt_a   = r_gnt_a;
  assign gnt_b   = r_gnt_b;
  assign done    = r_done;
  assign aborted = r_aborted;
  assign owner   = r_owner;
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_clk_burst_scheduler.sv
// Scoreboard bench for clk_burst_scheduler: each scenario pushes the expected
// per-cycle output vector {gnt_a,gnt_b,clk_out,done,aborted,busy,owner} and
// pops/compares one entry per cycle on the falling edge.
module tb_clk_burst_scheduler;

  logic       fastclk = 1'b0;
  logic       reset   = 1'b1;
  logic       req_a   = 1'b0;
  logic       req_b   = 1'b0;
  logic [7:0] len_a   = 8'd0;
  logic [7:0] len_b   = 8'd0;
  logic       mode_a  = 1'b0;
  logic       mode_b  = 1'b0;
  logic       abort   = 1'b0;
  logic       gnt_a, gnt_b, clk_out, busy, owner, done, aborted;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [6:0] expQ[$];

  clk_burst_scheduler dut (
    .fastclk (fastclk),
    .reset   (reset),
    .req_a   (req_a),
    .req_b   (req_b),
    .len_a   (len_a),
    .len_b   (len_b),
    .mode_a  (mode_a),
    .mode_b  (mode_b),
    .abort   (abort),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .clk_out (clk_out),
    .busy    (busy),
    .owner   (owner),
    .done    (done),
    .aborted (aborted)
  );

  always #5 fastclk = ~fastclk;

  task automatic pushExp(input logic ga, input logic gb, input logic ck, input logic dn,
                         input logic ab, input logic bz, input logic ow);
    expQ.push_back({ga, gb, ck, dn, ab, bz, ow});
  endtask

  // Expected trace of one burst: RUN cycles starting with the grant, then GAP.
  task automatic pushBurst(input logic isB, input int len, input logic mode, input int abortCycle);
    int period;
    int natural;
    int runCycles;
    logic wasAborted;
    period     = mode ? 4 : 2;
    natural    = (len == 0) ? 1 : len * period;
    runCycles  = natural;
    wasAborted = 1'b0;
    if (abortCycle > 0 && abortCycle <= natural) begin
      runCycles  = abortCycle;
      wasAborted = 1'b1;
    end
    for (int i = 1; i <= runCycles; i++) begin
      pushExp((i == 1) && !isB, (i == 1) && isB, (len != 0) && (((i - 1) % period) == 0),
              1'b0, 1'b0, 1'b1, isB);
    end
    pushExp(1'b0, 1'b0, 1'b0, 1'b1, wasAborted, 1'b1, isB);
  endtask

  task automatic test_reset();
    int cyc;
    logic [6:0] expv, obsv;
    cyc = 0;
    expQ.delete();
    reset = 1'b1;
    pushExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    while (expQ.size() > 0) begin
      @(posedge fastclk); @(negedge fastclk); cyc++;
      expv = expQ.pop_front();
      obsv = {gnt_a, gnt_b, clk_out, done, aborted, busy, owner};
      vectors++;
      if (obsv !== expv) begin
        miscompares++;
        $display("[TB] FAIL reset cyc %0d: got %b want %b", cyc, obsv, expv);
      end
      reset = 1'b0;
    end
  endtask

  task automatic test_single_div2();
    int cyc;
    logic [6:0] expv, obsv;
    cyc = 0;
    expQ.delete();
    req_a = 1'b1; len_a = 8'd3; mode_a = 1'b0;
    pushBurst(1'b0, 3, 1'b0, 0);
    pushExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    while (expQ.size() > 0) begin
      @(posedge fastclk); @(negedge fastclk); cyc++;
      expv = expQ.pop_front();
      obsv = {gnt_a, gnt_b, clk_out, done, aborted, busy, owner};
      vectors++;
      if (obsv !== expv) begin
        miscompares++;
        $display("[TB] FAIL single_div2 cyc %0d: got %b want %b", cyc, obsv, expv);
      end
      if (cyc == 1) req_a = 1'b0;
    end
  endtask

  task automatic test_div4_b();
    int cyc;
    logic [6:0] expv, obsv;
    cyc = 0;
    expQ.delete();
    req_b = 1'b1; len_b = 8'd2; mode_b = 1'b1;
    pushBurst(1'b1, 2, 1'b1, 0);
    pushExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    while (expQ.size() > 0) begin
      @(posedge fastclk); @(negedge fastclk); cyc++;
      expv = expQ.pop_front();
      obsv = {gnt_a, gnt_b, clk_out, done, aborted, busy, owner};
      vectors++;
      if (obsv !== expv) begin
        miscompares++;
        $display("[TB] FAIL div4_b cyc %0d: got %b want %b", cyc, obsv, expv);
      end
      if (cyc == 1) req_b = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [6:0] expv, obsv;
    cyc = 0;
    expQ.delete();
    req_a = 1'b1; req_b = 1'b1;
    len_a = 8'd1; len_b = 8'd1; mode_a = 1'b0; mode_b = 1'b0;
    pushBurst(1'b0, 1, 1'b0, 0);
    pushBurst(1'b1, 1, 1'b0, 0);
    pushBurst(1'b0, 1, 1'b0, 0);
    pushExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    while (expQ.size() > 0) begin
      @(posedge fastclk); @(negedge fastclk); cyc++;
      expv = expQ.pop_front();
      obsv = {gnt_a, gnt_b, clk_out, done, aborted, busy, owner};
      vectors++;
      if (obsv !== expv) begin
        miscompares++;
        $display("[TB] FAIL back_to_back cyc %0d: got %b want %b", cyc, obsv, expv);
      end
      if (cyc == 7) begin
        req_a = 1'b0;
        req_b = 1'b0;
      end
    end
  endtask

  task automatic test_len_zero();
    int cyc;
    logic [6:0] expv, obsv;
    cyc = 0;
    expQ.delete();
    req_a = 1'b1; len_a = 8'd0; mode_a = 1'b0;
    pushBurst(1'b0, 0, 1'b0, 0);
    pushExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    while (expQ.size() > 0) begin
      @(posedge fastclk); @(negedge fastclk); cyc++;
      expv = expQ.pop_front();
      obsv = {gnt_a, gnt_b, clk_out, done, aborted, busy, owner};
      vectors++;
      if (obsv !== expv) begin
        miscompares++;
        $display("[TB] FAIL len_zero cyc %0d: got %b want %b", cyc, obsv, expv);
      end
      if (cyc == 1) req_a = 1'b0;
    end
  endtask

  task automatic test_abort(input int len, input int abortCycle);
    int cyc;
    logic [6:0] expv, obsv;
    cyc = 0;
    expQ.delete();
    req_a = 1'b1; len_a = 8'(len); mode_a = 1'b0;
    pushBurst(1'b0, len, 1'b0, abortCycle);
    pushExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    while (expQ.size() > 0) begin
      @(posedge fastclk); @(negedge fastclk); cyc++;
      expv = expQ.pop_front();
      obsv = {gnt_a, gnt_b, clk_out, done, aborted, busy, owner};
      vectors++;
      if (obsv !== expv) begin
        miscompares++;
        $display("[TB] FAIL abort_len%0d cyc %0d: got %b want %b", len, cyc, obsv, expv);
      end
      if (cyc == 1) req_a = 1'b0;
      abort = (cyc == abortCycle);
    end
    abort = 1'b0;
  endtask

  task automatic test_mid_burst_reset();
    int cyc;
    logic [6:0] expv, obsv;
    cyc = 0;
    expQ.delete();
    req_a = 1'b1; len_a = 8'd5; mode_a = 1'b0;
    pushExp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    pushExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pushExp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    pushExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pushBurst(1'b0, 1, 1'b0, 0);
    pushExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    while (expQ.size() > 0) begin
      @(posedge fastclk); @(negedge fastclk); cyc++;
      expv = expQ.pop_front();
      obsv = {gnt_a, gnt_b, clk_out, done, aborted, busy, owner};
      vectors++;
      if (obsv !== expv) begin
        miscompares++;
        $display("[TB] FAIL mid_burst_reset cyc %0d: got %b want %b", cyc, obsv, expv);
      end
      if (cyc == 1) req_a = 1'b0;
      if (cyc == 3) reset = 1'b1;
      if (cyc == 4) begin
        reset = 1'b0;
        req_a = 1'b1; req_b = 1'b1;
        len_a = 8'd1; len_b = 8'd1;
        mode_a = 1'b0; mode_b = 1'b0;
      end
      if (cyc == 5) begin
        req_a = 1'b0;
        req_b = 1'b0;
      end
    end
  endtask

  initial begin
    @(negedge fastclk);
    test_reset();
    test_single_div2();
    test_div4_b();
    test_back_to_back();
    test_len_zero();
    test_abort(10, 4);
    test_abort(1, 2);
    test_mid_burst_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
